// File: rtl/sigmoid_arbiter_if.sv
// Handshake bundle between the requesters, the shared sigmoid arbiter and the result consumer.
// Requester side: req_valid/req_data in, one-hot req_ready back. Result side: out_valid/out_data/out_id out, out_ready back.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives requests and consumes results.
interface sigmoid_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = 24,
    parameter int OUT_W   = 8
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*IN_W-1:0] req_data;   // requester i at [i*IN_W +: IN_W], signed
    logic [NUM_REQ-1:0]      req_ready;  // one-hot grant
    logic                    out_valid;
    logic [OUT_W-1:0]        out_data;
    logic [ID_W-1:0]         out_id;
    logic                    out_ready;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_id
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_id
    );
endinterface

// File: rtl/sigmoid_arbiter.sv
// Round-robin arbiter sharing one combinational PLAN sigmoid among NUM_REQ accumulator drains.
// Latency: accept in cycle T -> out_valid with result in cycle T+2; 1 result/cycle with out_ready high.
// Backpressure: out_ready low holds S2, then S1; req_ready drops once both stages are occupied.
// Ports: clk, rst (sync, active-high), bus (sigmoid_arbiter_if.slave: req_valid/req_data/req_ready,
//        out_valid/out_data/out_id/out_ready).
// Optional macro SIGMOID_ARB_PERF_EN: adds perf_accepted / perf_stalls saturating 32b counters.
module sigmoid_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IN_W    = 24,
    parameter int OUT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    sigmoid_arbiter_if.slave  bus
`ifdef SIGMOID_ARB_PERF_EN
    ,
    output logic [31:0]       perf_accepted,
    output logic [31:0]       perf_stalls
`endif
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);

    // Sigmoid breakpoints: input is fixed point with 7 fraction bits, so 1.0 == 128.
    // PLAN segments |x| < 1, < 2.375, < 5 and saturation, scaled to a 0..128 output.
    localparam logic signed [IN_W-1:0] B_P1 = IN_W'(128);
    localparam logic signed [IN_W-1:0] B_P2 = IN_W'(304);
    localparam logic signed [IN_W-1:0] B_P3 = IN_W'(640);
    localparam logic signed [IN_W-1:0] B_N1 = IN_W'(-128);
    localparam logic signed [IN_W-1:0] B_N2 = IN_W'(-304);
    localparam logic signed [IN_W-1:0] B_N3 = IN_W'(-640);
    localparam logic signed [IN_W-1:0] C_MID = IN_W'(64);   // 0.5
    localparam logic signed [IN_W-1:0] C_P2  = IN_W'(80);   // 0.625
    localparam logic signed [IN_W-1:0] C_P3  = IN_W'(108);  // 0.84375
    localparam logic signed [IN_W-1:0] C_N2  = IN_W'(48);   // 1 - 0.625
    localparam logic signed [IN_W-1:0] C_N3  = IN_W'(20);   // 1 - 0.84375
    localparam logic signed [IN_W-1:0] C_SAT = IN_W'(127);  // 1.0 clipped to the 7-bit range

    // Pipeline state
    logic                   s1_valid;
    logic signed [IN_W-1:0] s1_data;
    logic [ID_W-1:0]        s1_id;
    logic                   s2_valid;
    logic [OUT_W-1:0]       s2_data;
    logic [ID_W-1:0]        s2_id;
    logic [ID_W-1:0]        rr_ptr;

    logic s2_free;
    logic s1_free;

    assign s2_free = !s2_valid || bus.out_ready;
    assign s1_free = !s1_valid || s2_free;

    // Arbitration: rotate the request vector so that bit 0 is the requester at rr_ptr,
    // take the lowest set bit, then rotate the offset back into an absolute id.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_W-1:0]      pick_off;
    logic                 pick_any;
    logic [ID_W:0]        id_sum;
    logic [ID_W-1:0]      grant_id;
    logic [NUM_REQ-1:0]   grant_vec;
    logic [IN_W-1:0]      sel_data;
    logic                 accept;

    assign req_dbl = {bus.req_valid, bus.req_valid};
    assign req_rot = req_dbl[rr_ptr +: NUM_REQ];

    always_comb begin
        pick_off = '0;
        pick_any = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_off = ID_W'(k);
                pick_any = 1'b1;
            end
        end
    end

    assign id_sum   = {1'b0, rr_ptr} + {1'b0, pick_off};
    assign grant_id = (id_sum >= NUM_REQ_X) ? ID_W'(id_sum - NUM_REQ_X) : id_sum[ID_W-1:0];

    always_comb begin
        grant_vec = '0;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_vec[i] = pick_any && (grant_id == ID_W'(i));
            if (grant_id == ID_W'(i)) begin
                sel_data = bus.req_data[i*IN_W +: IN_W];
            end
        end
    end

    // rst gates the grant so nothing is offered while the pipeline is being cleared.
    assign bus.req_ready = (s1_free && !rst) ? grant_vec : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);

    // Sigmoid on the S1 register (combinational). Arithmetic shifts floor toward -inf,
    // which keeps negative segments continuous with the positive ones.
    logic signed [IN_W-1:0] sig_val;
    logic [OUT_W-1:0]       sig_out;
    logic                   unused_sig_hi;

    always_comb begin
        if (s1_data >= B_P3) begin
            sig_val = C_SAT;
        end else if (s1_data >= B_P2) begin
            sig_val = C_P3 + (s1_data >>> 5);
        end else if (s1_data >= B_P1) begin
            sig_val = C_P2 + (s1_data >>> 3);
        end else if (s1_data >= B_N1) begin
            sig_val = C_MID + (s1_data >>> 2);
        end else if (s1_data >= B_N2) begin
            sig_val = C_N2 + (s1_data >>> 3);
        end else if (s1_data >= B_N3) begin
            sig_val = C_N3 + (s1_data >>> 5);
        end else begin
            sig_val = '0;
        end
    end

    // Every segment lands in 0..127, so the upper bits are always zero.
    assign sig_out       = sig_val[OUT_W-1:0];
    assign unused_sig_hi = ^sig_val[IN_W-1:OUT_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_id    <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_id    <= '0;
            rr_ptr   <= '0;
        end else begin
            if (s1_free) begin
                s1_valid <= accept;
                if (accept) begin
                    s1_data <= sel_data;
                    s1_id   <= grant_id;
                    rr_ptr  <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
                end
            end
            if (s2_free) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= sig_out;
                    s2_id   <= s1_id;
                end
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_id    = s2_id;

`ifdef SIGMOID_ARB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_accepted <= '0;
            perf_stalls   <= '0;
        end else begin
            if (accept && (perf_accepted != '1)) begin
                perf_accepted <= perf_accepted + 32'd1;
            end
            if (s2_valid && !bus.out_ready && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif
endmodule
